uart_tx_engine: RTL

- Transmit stage directly downstream of ahb_slave.
- Consumes bytes written to the TDR register and line settings taken from the LCR, OCR and FCR fields; produces a serial UART TX line.
- Buffers bytes in a TX FIFO, serialises them at a programmable bit period, and returns FIFO/busy status for the LSR (lsr_i) and IIR (iir_i) inputs of ahb_slave.

---
 rtl/uart_tx_engine.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
`timescale 1ns/1ps
// uart_tx_engine: TX FIFO feeding a UART frame serialiser (start/data/parity/stop).
// Define UART_TX_PARITY_EN to build the parity bit stage; otherwise parity inputs are ignored.
module uart_tx_engine #(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic                          wr_en_i,
   input  logic [7:0]                    wr_data_i,
   input  logic [1:0]                    data_bits_i,
   input  logic                          stop_bits_i,
   input  logic                          parity_en_i,
   input  logic                          parity_even_i,
   input  logic [DIV_W-1:0]              baud_div_i,
   input  logic                          fifo_clr_i,
   output logic                          tx_o,
   output logic                          tx_busy_o,
   output logic                          fifo_empty_o,
   output logic                          fifo_full_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          ovf_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_nxt;
   logic             push;
   logic             pop;

   state_t           state;
   logic [DIV_W-1:0] timer;
   logic [DIV_W-1:0] div_last;
   logic [7:0]       shreg;
   logic [2:0]       bit_idx;
   logic [1:0]       dbits;
   logic             stop2;
   logic             tick;
   logic             last_stop;
   logic             last_data;

`ifdef UART_TX_PARITY_EN
   logic             par;
   logic             par_en;
   logic             par_even;
`else
   logic             unused;
   assign unused = ^{parity_en_i, parity_even_i};
`endif

   assign push      = wr_en_i && !fifo_full_o && !fifo_clr_i;
   assign tick      = (timer == div_last);
   assign last_stop = !stop2 || bit_idx[0];
   assign last_data = (bit_idx == ({1'b0, dbits} + 3'd4));

   // Popping only ever happens on a frame boundary; empty is the registered flag.
   always_comb begin
      pop = 1'b0;
      if (!fifo_empty_o) begin
         if (state == IDLE)
            pop = 1'b1;
         else if (state == STOP && tick && last_stop)
            pop = 1'b1;
      end
   end

   always_comb begin
      count_nxt = fifo_count_o;
      if (fifo_clr_i)
         count_nxt = '0;
      else
         count_nxt = fifo_count_o + CW'(push) - CW'(pop);
   end

   always_ff @(posedge HCLK) begin
      if (push)
         mem[wr_ptr] <= wr_data_i;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count_o <= '0;
         fifo_empty_o <= 1'b1;
         fifo_full_o  <= 1'b0;
         ovf_o        <= 1'b0;
      end else begin
         ovf_o        <= wr_en_i && fifo_full_o && !fifo_clr_i;
         fifo_count_o <= count_nxt;
         fifo_empty_o <= (count_nxt == '0);
         fifo_full_o  <= (count_nxt == CW'(FIFO_DEPTH));
         if (fifo_clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= IDLE;
         tx_o      <= 1'b1;
         tx_busy_o <= 1'b0;
         timer     <= '0;
         div_last  <= '0;
         shreg     <= '0;
         bit_idx   <= '0;
         dbits     <= '0;
         stop2     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par       <= 1'b0;
         par_en    <= 1'b0;
         par_even  <= 1'b0;
`endif
      end else if (pop) begin
         // Frame settings are frozen here; later input changes wait for the next frame.
         state     <= START;
         tx_o      <= 1'b0;
         tx_busy_o <= 1'b1;
         timer     <= '0;
         div_last  <= (baud_div_i == '0) ? '0 : baud_div_i - 1'b1;
         shreg     <= mem[rd_ptr];
         bit_idx   <= '0;
         dbits     <= data_bits_i;
         stop2     <= stop_bits_i;
`ifdef UART_TX_PARITY_EN
         par       <= 1'b0;
         par_en    <= parity_en_i;
         par_even  <= parity_even_i;
`endif
      end else begin
         if (state != IDLE)
            timer <= tick ? '0 : timer + 1'b1;
         unique case (state)
            IDLE: begin
               tx_o <= 1'b1;
            end
            START: begin
               if (tick) begin
                  state <= DATA;
                  tx_o  <= shreg[0];
                  shreg <= shreg >> 1;
`ifdef UART_TX_PARITY_EN
                  par   <= par ^ shreg[0];
`endif
               end
            end
            DATA: begin
               if (tick && !last_data) begin
                  bit_idx <= bit_idx + 1'b1;
                  tx_o    <= shreg[0];
                  shreg   <= shreg >> 1;
`ifdef UART_TX_PARITY_EN
                  par     <= par ^ shreg[0];
`endif
               end else if (tick) begin
`ifdef UART_TX_PARITY_EN
                  if (par_en) begin
                     state <= PARITY;
                     tx_o  <= par ^ ~par_even;
                  end else
`endif
                  begin
                     state   <= STOP;
                     tx_o    <= 1'b1;
                     bit_idx <= '0;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  state   <= STOP;
                  tx_o    <= 1'b1;
                  bit_idx <= '0;
               end
            end
`endif
            STOP: begin
               if (tick && last_stop) begin
                  state     <= IDLE;
                  tx_busy_o <= 1'b0;
               end else if (tick) begin
                  bit_idx <= 3'd1;
               end
            end
            default: begin
               state <= IDLE;
               tx_o  <= 1'b1;
            end
         endcase
      end
   end

endmodule
